// File: rtl/wide_add_seq_if.sv
// Bundle of the request, result and word-adder signals of the multi-precision add sequencer.
// Widths follow WIDTH (adder word) and NWORDS (words per operand).
// slave = the sequencer itself; master = whatever drives requests and hosts the word adder.
interface wide_add_seq_if #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
);
    localparam int W = WIDTH * NWORDS;

    // request side
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_cin;

    // word adder side
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sm_r;

    // result side
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_cout;
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sm_r, out_ready,
        output in_ready, add_x, add_y, add_cin, out_valid, out_sum, out_cout, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sm_r, out_ready,
        input  in_ready, add_x, add_y, add_cin, out_valid, out_sum, out_cout, out_zero
    );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-precision adder: ripples a wide A+B+cin through one registered WIDTH-bit adder, LSW first.
// Latency: out_valid rises 2*NWORDS cycles after the accept edge (issue + wait per word).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, outputs held until the next result.
module wide_add_seq #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int W     = WIDTH * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             carry_q,    carry_d;
    logic [W-1:0]     a_q,        a_d;
    logic [W-1:0]     b_q,        b_d;
    logic [W-1:0]     sum_q,      sum_d;
    logic [W-1:0]     out_sum_q,  out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_zero_q, out_zero_d;

    logic [WIDTH-1:0] add_x_c;
    logic [WIDTH-1:0] add_y_c;
    logic             add_cin_c;

    // Next-state, word steering and result capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_zero_d = out_zero_q;
        add_x_c    = '0;
        add_y_c    = '0;
        add_cin_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                add_x_c   = a_q[idx_q*WIDTH +: WIDTH];
                add_y_c   = b_q[idx_q*WIDTH +: WIDTH];
                add_cin_c = carry_q;
                state_d   = WAIT;
            end
            WAIT: begin
                // Adder output is registered: it now holds the word issued last cycle.
                sum_d[idx_q*WIDTH +: WIDTH] = bus.add_sm_r[WIDTH-1:0];
                carry_d                     = bus.add_sm_r[WIDTH];
                if (idx_q == LAST_IDX) begin
                    // Publish only a complete sum so the outputs never show partial words.
                    out_sum_d  = sum_d;
                    out_cout_d = bus.add_sm_r[WIDTH];
                    out_zero_d = (sum_d == '0) && !bus.add_sm_r[WIDTH];
                    state_d    = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_zero_q <= out_zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.add_x     = add_x_c;
    assign bus.add_y     = add_y_c;
    assign bus.add_cin   = add_cin_c;
endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq (WIDTH=8, NWORDS=4) with a registered word-adder model attached.
// A cycle-count model of the request/result protocol is compared against the DUT every cycle.
// Directed vectors add literal expectations for results and latency.
module tb_wide_add_seq;
    localparam int WD  = 8;
    localparam int NW  = 4;
    localparam int WW  = WD * NW;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    wide_add_seq_if #(.WIDTH(WD), .NWORDS(NW)) bus ();

    wide_add_seq #(.WIDTH(WD), .NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered word adder, 1-cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.add_sm_r <= '0;
        else     bus.add_sm_r <= {1'b0, bus.add_x} + {1'b0, bus.add_y} + {{WD{1'b0}}, bus.add_cin};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol-level model: idle -> busy for 2*NW edges -> done until out_ready.
    logic          m_idle, m_done;
    int            m_cnt;
    logic [WW-1:0] m_a, m_b;
    logic          m_cin;
    logic [WW-1:0] m_out_sum;
    logic          m_out_cout, m_out_zero;

    always @(posedge clk or posedge rst) begin : model
        logic [WW:0] full;
        if (rst) begin
            m_idle <= 1'b1; m_done <= 1'b0; m_cnt <= 0;
            m_out_sum <= '0; m_out_cout <= 1'b0; m_out_zero <= 1'b0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
                m_idle <= 1'b0; m_cnt <= 2 * NW;
                m_a <= bus.in_a; m_b <= bus.in_b; m_cin <= bus.in_cin;
            end
        end else if (!m_done) begin
            if (m_cnt == 1) begin
                full       = {1'b0, m_a} + {1'b0, m_b} + {{WW{1'b0}}, m_cin};
                m_done     <= 1'b1;
                m_out_sum  <= full[WW-1:0];
                m_out_cout <= full[WW];
                m_out_zero <= (full == '0);
            end
            m_cnt <= m_cnt - 1;
        end else if (bus.out_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [63:0] ex_x, ex_y, ex_cin, mask;
        int k;
        ex_x = 0; ex_y = 0; ex_cin = 0;
        if (!m_idle && !m_done && (m_cnt % 2 == 0)) begin
            k      = (2 * NW - m_cnt) / 2;
            ex_x   = ({32'd0, m_a} >> (WD * k)) & 64'hFF;
            ex_y   = ({32'd0, m_b} >> (WD * k)) & 64'hFF;
            mask   = (64'd1 << (WD * k)) - 64'd1;
            ex_cin = ((({32'd0, m_a} & mask) + ({32'd0, m_b} & mask) + {63'd0, m_cin}) >> (WD * k)) & 64'd1;
        end
        chk("in_ready",  bus.in_ready,  m_idle);
        chk("out_valid", bus.out_valid, m_done);
        chk("out_sum",   bus.out_sum,   m_out_sum);
        chk("out_cout",  bus.out_cout,  m_out_cout);
        chk("out_zero",  bus.out_zero,  m_out_zero);
        chk("add_x",     bus.add_x,     ex_x);
        chk("add_y",     bus.add_y,     ex_y);
        chk("add_cin",   bus.add_cin,   ex_cin);
    end

    // Present a request, then scramble operands and count cycles until out_valid.
    task automatic do_req(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic c, output int cyc);
        int g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("accept_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = c;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_cin = 1'b1;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic expect_res(input string name, input int cyc, input logic [WW-1:0] s,
                              input logic co, input logic z);
        chk({name, "_latency"}, cyc, 8);
        chk({name, "_sum"},  bus.out_sum,  s);
        chk({name, "_cout"}, bus.out_cout, co);
        chk({name, "_zero"}, bus.out_zero, z);
        chk({name, "_model_sum"},  m_out_sum,  s);
        chk({name, "_model_cout"}, m_out_cout, co);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("ack_valid_drop", bus.out_valid, 0);
        chk("ack_ready_back", bus.in_ready, 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  bus.in_ready,  1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_sum",   bus.out_sum,   0);
        chk("reset_out_zero",  bus.out_zero,  0);
        chk("reset_add_x",     bus.add_x,     0);

        // 1: carry across one word boundary
        do_req(32'h000000FF, 32'h00000001, 1'b0, cyc);
        expect_res("t1", cyc, 32'h00000100, 1'b0, 1'b0);
        ack();

        // 2: full ripple into carry-out
        do_req(32'hFFFFFFFF, 32'h00000001, 1'b0, cyc);
        expect_res("t2", cyc, 32'h00000000, 1'b1, 1'b0);
        ack();

        // 3: all zero
        do_req(32'h0, 32'h0, 1'b0, cyc);
        expect_res("t3", cyc, 32'h00000000, 1'b0, 1'b1);
        ack();

        // 4: carry-in ripple, then a plain add
        do_req(32'hFFFFFFFF, 32'h00000000, 1'b1, cyc);
        expect_res("t4a", cyc, 32'h00000000, 1'b1, 1'b0);
        ack();
        do_req(32'h12345678, 32'h11111111, 1'b0, cyc);
        expect_res("t4b", cyc, 32'h23456789, 1'b0, 1'b0);
        ack();

        // 5: hold off the result for 5 cycles, with a stray request in between
        do_req(32'h0F0F0F0F, 32'h01010101, 1'b1, cyc);
        expect_res("t5", cyc, 32'h10101011, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.in_valid = 1'b1; bus.in_a = 32'h1; bus.in_b = 32'h1; bus.in_cin = 1'b0;
            end
            if (i == 2) bus.in_valid = 1'b0;
            chk("t5_hold_valid", bus.out_valid, 1);
            chk("t5_hold_ready", bus.in_ready,  0);
            chk("t5_hold_sum",   bus.out_sum,   32'h10101011);
        end
        bus.in_valid = 1'b0;
        ack();

        // 6: reset during the third WAIT, then a fresh request
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = 32'hAAAAAAAA; bus.in_b = 32'h55555555; bus.in_cin = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_sum",   bus.out_sum,   0);
        chk("t6_rst_cout",  bus.out_cout,  0);
        chk("t6_rst_zero",  bus.out_zero,  0);
        chk("t6_rst_add_x", bus.add_x,     0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", bus.in_ready, 1);
        do_req(32'h00000001, 32'h00000002, 1'b0, cyc);
        expect_res("t6", cyc, 32'h00000003, 1'b0, 1'b0);
        ack();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
